// File: rtl/kaktovik_scan_ctrl.sv
// kaktovik_scan_ctrl: binary to base-20 converter and one-hot digit scanner for a shared kaktovik decoder.
// Define KAKTOVIK_SCAN_BLANK_EN for leading-zero blanking through dec_rbi.
module kaktovik_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1000,
  parameter int GUARD    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [NDIG-1:0]  dig_sel,
  output logic [4:0]       dec_value,
  output logic             dec_rbi,
  output logic             dec_bi
);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PL = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] GD = PW'(GUARD);
  localparam logic [IW-1:0] IL = IW'(NDIG - 1);
  localparam logic [BW-1:0] BL = BW'(WIDTH - 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] div, div_nx;
  logic [4:0] rem, rem_nx;
  logic [5:0] sh;
  logic [BW-1:0] bcnt;
  logic [IW-1:0] k, idx;
  logic [PW-1:0] presc;
  logic [NDIG-1:0][4:0] shadow, bank, commit;
  logic [NDIG-1:0] rbi_v;
  logic last_bit, last_dig, on;
`ifdef KAKTOVIK_SCAN_BLANK_EN
  logic lead;
`endif
  assign busy = state == CONV;
  assign on = enable && presc >= GD;
  always_comb begin
    sh = {rem, div[WIDTH-1]};
    rem_nx = sh >= 6'd20 ? 5'(sh - 6'd20) : sh[4:0];
    div_nx = (div << 1) | WIDTH'(sh >= 6'd20);
    last_bit = bcnt == BL;
    last_dig = k == IL;
    commit = shadow;
    commit[k] = rem_nx;
    state_nx = load ? CONV : (state == CONV && last_bit && last_dig) ? IDLE : state;
`ifdef KAKTOVIK_SCAN_BLANK_EN
    lead = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lead = lead && bank[i] == 5'd0;
      rbi_v[i] = !lead || i == 0;
    end
`else
    rbi_v = '1;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // the last step of the last digit commits straight from the divider so done lands one cycle after busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      rem <= '0;
      bcnt <= '0;
      k <= '0;
      shadow <= '0;
      bank <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        div <= value;
        rem <= '0;
        bcnt <= '0;
        k <= '0;
      end else if (state == CONV) begin
        div <= div_nx;
        rem <= last_bit ? 5'd0 : rem_nx;
        bcnt <= last_bit ? '0 : bcnt + BW'(1);
        if (last_bit) begin
          shadow[k] <= rem_nx;
          k <= k + IW'(1);
        end
        if (last_bit && last_dig) begin
          bank <= commit;
          overflow <= div_nx != '0;
          done <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx <= '0;
      dig_sel <= '0;
      dec_value <= '0;
      dec_rbi <= 1'b1;
      dec_bi <= 1'b0;
    end else begin
      presc <= presc == PL ? '0 : presc + PW'(1);
      if (presc == PL) idx <= idx == IL ? '0 : idx + IW'(1);
      dig_sel <= on ? NDIG'(1) << idx : '0;
      dec_bi <= on;
      dec_value <= bank[idx];
      dec_rbi <= rbi_v[idx];
    end
  end
endmodule

// File: tb/tb_kaktovik_scan_ctrl.sv
// tb_kaktovik_scan_ctrl: scoreboard bench with a base-20 arithmetic reference and a time-based scan model.
module tb_kaktovik_scan_ctrl;
  localparam int NDIG = 3, WIDTH = 16, PRESCALE = 4, GUARD = 1;
  localparam longint LAT = NDIG * WIDTH + 1;
  logic clk = 1'b0, rst_n = 1'b1, load = 1'b0, enable = 1'b1;
  logic [WIDTH-1:0] value = '0;
  logic busy, done, overflow, dec_rbi, dec_bi;
  logic [NDIG-1:0] dig_sel;
  logic [4:0] dec_value;
  typedef struct {longint v; longint due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  longint cyc = 0, s = 0;
  logic en_s = 1'b0;
  longint mdig[NDIG];
  longint mrbi[NDIG];

  kaktovik_scan_ctrl #(.NDIG(NDIG), .WIDTH(WIDTH), .PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .enable(enable),
    .busy(busy), .done(done), .overflow(overflow), .dig_sel(dig_sel),
    .dec_value(dec_value), .dec_rbi(dec_rbi), .dec_bi(dec_bi)
  );

  always #5 clk = ~clk;

  function automatic longint p20(int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 20;
    return p;
  endfunction

  function automatic void model_set(longint v);
    longint vm = v % p20(NDIG);
    for (int i = 0; i < NDIG; i++) begin
      mdig[i] = (vm / p20(i)) % 20;
`ifdef KAKTOVIK_SCAN_BLANK_EN
      mrbi[i] = (i == 0 || vm / p20(i) != 0) ? 1 : 0;
`else
      mrbi[i] = 1;
`endif
    end
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      s <= s + 1;
      en_s <= enable;
    end
  end

  always @(negedge clk) begin
    longint ph, sl;
    bit on;
    exp_t e;
    if (rst_n) begin
      if (s >= 1) begin
        ph = (s - 1) % PRESCALE;
        sl = ((s - 1) / PRESCALE) % NDIG;
        on = en_s && ph >= GUARD;
        chk("dig_sel", longint'(dig_sel), on ? (longint'(1) << sl) : 0);
        chk("dec_bi", longint'(dec_bi), on ? 1 : 0);
        chk("dec_value", longint'(dec_value), mdig[sl]);
        chk("dec_rbi", longint'(dec_rbi), mrbi[sl]);
      end
      if (done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc, e.due);
          chk("overflow", longint'(overflow), e.v >= p20(NDIG) ? 1 : 0);
          chk("busy_at_done", longint'(busy), 0);
          model_set(e.v);
        end
      end
    end
  end

  task automatic do_load(longint v);
    @(negedge clk);
    if (q.size() > 0) void'(q.pop_back());
    q.push_back('{v, cyc + LAT});
    value = WIDTH'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_after_load", longint'(busy), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected %0d pending", q.size());
      q.delete();
    end
  endtask

  initial begin
    model_set(0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_overflow", longint'(overflow), 0);
    chk("rst_dig_sel", longint'(dig_sel), 0);
    chk("rst_dec_value", longint'(dec_value), 0);
    chk("rst_dec_rbi", longint'(dec_rbi), 1);
    chk("rst_dec_bi", longint'(dec_bi), 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    do_load(0); wait_idle();
    do_load(65535); wait_idle();
    do_load(8000); wait_idle();
    do_load(7999); wait_idle();
    do_load(400); wait_idle();
    do_load(100);
    repeat (9) @(negedge clk);
    do_load(8000); wait_idle();
    do_load(2345); wait_idle();
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    enable = 1'b1;
    repeat (14) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      enable = $urandom_range(0, 3) != 0;
      do_load($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        do_load($urandom_range(0, 9000));
      end
      wait_idle();
      repeat ($urandom_range(0, 10)) @(negedge clk);
      enable = 1'b1;
      repeat (13) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
